cplx_weight_mult: RTL
=====================

Name: cplx_weight_mult

Overview:
- Downstream stage of the per-channel I/Q delay unit. Multiplies each delayed complex sample by a complex beamforming weight (steering/adaptive weight) before the channel-sum adder.
- Pipelined, with a valid qualifier and a double-buffered weight register: the adaptation engine loads a new weight in the background and commits it atomically.

Parameters:
- DW, 18, input sample width per rail (signed)
- WW, 18, weight width per rail (signed, Q1.(WW-1))
- OW, 18, output width per rail (signed)
- FRAC, 17, weight fraction bits removed after the multiply
- W_RST_I, 131071, reset value of the real weight part (≈ +1.0)
- W_RST_Q, 0, reset value of the imaginary weight part

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- din_valid  in  1  dinI/dinQ qualifier
- dinI  in  DW  signed real sample, from the delay unit
- dinQ  in  DW  signed imaginary sample
- w_load  in  1  capture w_inI/w_inQ into the shadow register
- w_inI  in  WW  signed new weight, real part
- w_inQ  in  WW  signed new weight, imaginary part
- w_commit  in  1  copy the shadow weight to the active weight
- dout_valid  out  1  doutI/doutQ qualifier
- doutI  out  OW  signed product, real part
- doutQ  out  OW  signed product, imaginary part
- sat_flag  out  1  high with dout_valid when either rail saturated

Behaviour:
- Reset, synchronous on rst high:
  - All pipeline data and valid registers go to 0.
  - doutI, doutQ, dout_valid and sat_flag go to 0.
  - Shadow and active weights both go to W_RST_I/W_RST_Q.
- Reset mid-stream: in-flight samples are discarded; no dout_valid pulse follows reset.
- Pipeline, fixed latency 4 (din_valid at edge N gives dout_valid high after edge N+4):
  - S1: register din, din_valid and the active weight.
  - S2: four full-width products, each DW+WW bits: dI·wI, dQ·wQ, dI·wQ, dQ·wI.
  - S3: I = dI·wI − dQ·wQ; Q = dI·wQ + dQ·wI; DW+WW+1 bits each.
  - S4: round by adding 2^(FRAC−1), then arithmetic-shift right by FRAC (round half toward +inf). Saturate to [−2^(OW−1), 2^(OW−1)−1]. Register outputs.
- Valid bubbles propagate. doutI/doutQ update only when S4 is valid and hold otherwise. dout_valid is high exactly one cycle per input sample; back-to-back throughput is 1 sample/clk.
- sat_flag is per-sample, aligned with dout_valid, and is 0 whenever dout_valid is 0.
- Weight double buffer:
  - w_load: shadow <= w_in.
  - w_commit: active <= shadow.
  - w_load and w_commit in the same cycle: active <= w_in directly (bypass); shadow <= w_in as well.
  - A sample accepted in the commit cycle uses the old active weight. A sample accepted in the next cycle uses the new one.
  - w_load alone never changes output values.
- Weight updates are accepted regardless of din_valid.
- −1.0 (−2^(WW−1)) is a legal weight. The −1 × −1 case overflows and saturates.

Decomposition:
- Shared package `bf_pkg`:
  - DW/WW/OW/FRAC defaults
  - Q1.17 constants ONE_Q = 131071, HALF_LSB = 2^(FRAC−1)
  - Saturation min/max constants, reused by the channel-sum adder
- One natural sub-module, `round_sat`: round-then-saturate of one rail, instantiated twice in S4 and reusable downstream.

Test Plan:
- Unity weight (reset value), din = 1000 + j500, single valid → dout = 1000 + j500 after exactly 4 clocks, sat_flag = 0.
- Weight 0 + j131071 loaded and committed, din = 1000 + j500 → dout = −500 + j1000.
- Weight −131072 + j0, din = −131072 − j131072 → dout = 131071 + j131071, sat_flag = 1 for that sample only.
- Continuous stream of 10 samples; w_load with a new weight mid-stream and w_commit 3 cycles later:
  - Outputs switch weight exactly at the first sample accepted after the commit cycle.
  - No gaps in dout_valid.
- Simultaneous w_load and w_commit with weight 0 + j0 → the next accepted sample outputs 0 + j0 (bypass path).
- rst asserted for 1 cycle with 3 samples in flight → dout_valid stays 0 and outputs are 0. The next sample uses the reset weight: 7 + j7 → 7 + j7.

Source files
------------

// File: rtl/bf_pkg.sv
// +--------------------------------------------------------------------+
// | bf_pkg : shared beamformer widths, Q1.17 constants, sat bounds      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package bf_pkg;

   localparam int DW_DEF   = 18;
   localparam int WW_DEF   = 18;
   localparam int OW_DEF   = 18;
   localparam int FRAC_DEF = 17;

   localparam int ONE_Q    = 131071;
   localparam int HALF_LSB = 2 ** (FRAC_DEF - 1);

   // Output clamp bounds, shared with the channel-sum adder
   localparam int SAT_MAX  = (2 ** (OW_DEF - 1)) - 1;
   localparam int SAT_MIN  = -(2 ** (OW_DEF - 1));

endpackage

`default_nettype wire

// File: rtl/round_sat.sv
// +--------------------------------------------------------------------+
// | round_sat : round half toward +inf, drop FRAC bits, clamp to OW     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module round_sat
   import bf_pkg::*;
#(
   parameter int IW   = DW_DEF + WW_DEF + 1,
   parameter int OW   = OW_DEF,
   parameter int FRAC = FRAC_DEF
) (
   input  logic signed [IW-1:0] din,
   output logic signed [OW-1:0] dout,
   output logic                 sat
);

   // One guard bit so the rounding add can never wrap
   localparam int EW  = IW + 1;
   localparam int SHW = EW - FRAC;

   localparam logic signed [EW-1:0]  HALF = EW'(1) << (FRAC - 1);
   localparam logic signed [SHW-1:0] MAXV = {{(SHW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [SHW-1:0] MINV = {{(SHW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   logic signed [EW-1:0]  rnd;
   logic signed [SHW-1:0] shf;
   logic                  over;
   logic                  under;

   always_comb begin
      rnd   = EW'(din) + HALF;
      shf   = SHW'(rnd >>> FRAC);
      over  = (shf > MAXV);
      under = (shf < MINV);
      sat   = over | under;
      if (over) begin
         dout = MAXV[OW-1:0];
      end else if (under) begin
         dout = MINV[OW-1:0];
      end else begin
         dout = shf[OW-1:0];
      end
   end

endmodule

`default_nettype wire

// File: rtl/cplx_weight_mult.sv
// +--------------------------------------------------------------------+
// | cplx_weight_mult : 4-stage complex sample x weight multiplier with  |
// | double-buffered weight. Rev 1.0                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module cplx_weight_mult
   import bf_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int WW      = WW_DEF,
   parameter int OW      = OW_DEF,
   parameter int FRAC    = FRAC_DEF,
   parameter int W_RST_I = ONE_Q,
   parameter int W_RST_Q = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din_valid,
   input  logic signed [DW-1:0] dinI,
   input  logic signed [DW-1:0] dinQ,
   input  logic                 w_load,
   input  logic signed [WW-1:0] w_inI,
   input  logic signed [WW-1:0] w_inQ,
   input  logic                 w_commit,
   output logic                 dout_valid,
   output logic signed [OW-1:0] doutI,
   output logic signed [OW-1:0] doutQ,
   output logic                 sat_flag
);

   localparam int PW = DW + WW;
   localparam int SW = PW + 1;
   localparam logic signed [WW-1:0] W_RST_RE = WW'(W_RST_I);
   localparam logic signed [WW-1:0] W_RST_IM = WW'(W_RST_Q);

   logic signed [WW-1:0] shd_re_q, shd_re_d, shd_im_q, shd_im_d;
   logic signed [WW-1:0] act_re_q, act_re_d, act_im_q, act_im_d;
   logic                 s1_valid_q, s1_valid_d;
   logic signed [DW-1:0] s1_d_re_q, s1_d_re_d, s1_d_im_q, s1_d_im_d;
   logic signed [WW-1:0] s1_w_re_q, s1_w_re_d, s1_w_im_q, s1_w_im_d;
   logic                 s2_valid_q, s2_valid_d;
   logic signed [PW-1:0] s2_rr_q, s2_rr_d, s2_ii_q, s2_ii_d;
   logic signed [PW-1:0] s2_ri_q, s2_ri_d, s2_ir_q, s2_ir_d;
   logic                 s3_valid_q, s3_valid_d;
   logic signed [SW-1:0] s3_re_q, s3_re_d, s3_im_q, s3_im_d;
   logic                 dout_valid_q, dout_valid_d;
   logic signed [OW-1:0] dout_re_q, dout_re_d, dout_im_q, dout_im_d;
   logic                 sat_q, sat_d;

   logic signed [OW-1:0] rs_re, rs_im;
   logic                 rs_re_sat, rs_im_sat;

   round_sat #(.IW(SW), .OW(OW), .FRAC(FRAC)) u_rs_re (
      .din  (s3_re_q),
      .dout (rs_re),
      .sat  (rs_re_sat)
   );

   round_sat #(.IW(SW), .OW(OW), .FRAC(FRAC)) u_rs_im (
      .din  (s3_im_q),
      .dout (rs_im),
      .sat  (rs_im_sat)
   );

   always_comb begin
      shd_re_d = w_load ? w_inI : shd_re_q;
      shd_im_d = w_load ? w_inQ : shd_im_q;
      // Simultaneous load+commit bypasses the shadow straight to active
      act_re_d = act_re_q;
      act_im_d = act_im_q;
      if (w_commit) begin
         act_re_d = w_load ? w_inI : shd_re_q;
         act_im_d = w_load ? w_inQ : shd_im_q;
      end

      s1_valid_d = din_valid;
      s1_d_re_d  = dinI;
      s1_d_im_d  = dinQ;
      s1_w_re_d  = act_re_q;
      s1_w_im_d  = act_im_q;

      s2_valid_d = s1_valid_q;
      s2_rr_d    = PW'(s1_d_re_q) * PW'(s1_w_re_q);
      s2_ii_d    = PW'(s1_d_im_q) * PW'(s1_w_im_q);
      s2_ri_d    = PW'(s1_d_re_q) * PW'(s1_w_im_q);
      s2_ir_d    = PW'(s1_d_im_q) * PW'(s1_w_re_q);

      s3_valid_d = s2_valid_q;
      s3_re_d    = SW'(s2_rr_q) - SW'(s2_ii_q);
      s3_im_d    = SW'(s2_ri_q) + SW'(s2_ir_q);

      dout_valid_d = s3_valid_q;
      dout_re_d    = s3_valid_q ? rs_re : dout_re_q;
      dout_im_d    = s3_valid_q ? rs_im : dout_im_q;
      sat_d        = s3_valid_q & (rs_re_sat | rs_im_sat);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shd_re_q     <= W_RST_RE;
         shd_im_q     <= W_RST_IM;
         act_re_q     <= W_RST_RE;
         act_im_q     <= W_RST_IM;
         s1_valid_q   <= 1'b0;
         s1_d_re_q    <= '0;
         s1_d_im_q    <= '0;
         s1_w_re_q    <= '0;
         s1_w_im_q    <= '0;
         s2_valid_q   <= 1'b0;
         s2_rr_q      <= '0;
         s2_ii_q      <= '0;
         s2_ri_q      <= '0;
         s2_ir_q      <= '0;
         s3_valid_q   <= 1'b0;
         s3_re_q      <= '0;
         s3_im_q      <= '0;
         dout_valid_q <= 1'b0;
         dout_re_q    <= '0;
         dout_im_q    <= '0;
         sat_q        <= 1'b0;
      end else begin
         shd_re_q     <= shd_re_d;
         shd_im_q     <= shd_im_d;
         act_re_q     <= act_re_d;
         act_im_q     <= act_im_d;
         s1_valid_q   <= s1_valid_d;
         s1_d_re_q    <= s1_d_re_d;
         s1_d_im_q    <= s1_d_im_d;
         s1_w_re_q    <= s1_w_re_d;
         s1_w_im_q    <= s1_w_im_d;
         s2_valid_q   <= s2_valid_d;
         s2_rr_q      <= s2_rr_d;
         s2_ii_q      <= s2_ii_d;
         s2_ri_q      <= s2_ri_d;
         s2_ir_q      <= s2_ir_d;
         s3_valid_q   <= s3_valid_d;
         s3_re_q      <= s3_re_d;
         s3_im_q      <= s3_im_d;
         dout_valid_q <= dout_valid_d;
         dout_re_q    <= dout_re_d;
         dout_im_q    <= dout_im_d;
         sat_q        <= sat_d;
      end
   end

   assign dout_valid = dout_valid_q;
   assign doutI      = dout_re_q;
   assign doutQ      = dout_im_q;
   assign sat_flag   = sat_q;

endmodule

`default_nettype wire
